// File: rtl/scheduler_port_sink.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// scheduler_port_sink
// Egress sink for one scheduler output port. It accepts AXI-Stream beats,
// paces tready with a rotating back-pressure pattern, tracks packet framing,
// checks the PIFO tag of every packet's first beat and counts rank inversions
// between consecutive packets. Statistics are read through an AXI4-Lite
// read-only slave.
//
// Ports:
//   axis_aclk, axis_resetn      clock, asynchronous active-low reset
//   sink_enable                 0 forces tready low
//   clear_counters              one-cycle synchronous clear of all statistics
//   s_axis_*                    AXI-Stream sink (tdata/tuser are not stored)
//   S_AXI_AR*, S_AXI_R*         AXI4-Lite read channel (no write channel)
// ---------------------------------------------------------------------------
module scheduler_port_sink #(
   parameter logic [7:0] READY_PATTERN      = 8'hFF,
   parameter int         C_S_AXI_ADDR_WIDTH = 32,
   parameter int         C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                          axis_aclk,
   input  logic                          axis_resetn,
   input  logic                          sink_enable,
   input  logic                          clear_counters,
   input  logic [255:0]                  s_axis_tdata,
   input  logic [31:0]                   s_axis_tkeep,
   input  logic [127:0]                  s_axis_tuser,
   input  logic [31:0]                   s_axis_tpifo,
   input  logic                          s_axis_tvalid,
   input  logic                          s_axis_tlast,
   output logic                          s_axis_tready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY
);

   typedef enum logic {ST_SOP = 1'b0, ST_BODY = 1'b1} frameState_t;

   localparam logic [31:0] ID_VALUE = 32'h5C4E_0001;

   frameState_t r_state;
   frameState_t w_stateNext;

   logic [2:0]  r_phase;
   logic        r_tready;
   logic [31:0] r_pktCount;
   logic [31:0] r_wordCount;
   logic [31:0] r_byteCount;
   logic [31:0] r_rankInvCount;
   logic [31:0] r_pifoErrCount;
   logic [18:0] r_lastRank;
   logic        r_hasPrev;
   logic        r_arready;
   logic        r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

   logic        w_xfer;
   logic        w_sopXfer;
   logic [18:0] w_rank;
   logic [5:0]  w_keepCount;
   logic [31:0] w_readMux;
   logic        w_unused;

   // Saturating add: counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [5:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {27'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   assign w_xfer      = s_axis_tvalid & r_tready;
   assign w_sopXfer   = w_xfer & (r_state == ST_SOP);
   assign w_rank      = s_axis_tpifo[30:12];
   assign w_keepCount = 6'($countones(s_axis_tkeep));

   // Payload, metadata, reserved tag bits and undecoded address bits are
   // deliberately ignored.
   assign w_unused = ^{s_axis_tdata, s_axis_tuser, s_axis_tpifo[11:0],
                       S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:6], S_AXI_ARADDR[1:0]};

   assign s_axis_tready = r_tready;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = 2'b00;

   // Back-pressure pacing: the phase counter walks the pattern LSB first and
   // tready is registered so it reflects the previous cycle's enable.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_phase  <= 3'd0;
         r_tready <= 1'b0;
      end else begin
         r_phase  <= r_phase + 3'd1;
         r_tready <= sink_enable & READY_PATTERN[r_phase];
      end
   end

   // Framing state register; never touched by clear_counters.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_state <= ST_SOP;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A tlast beat in SOP is a one-word packet and keeps the FSM in SOP.
   always_comb begin
      w_stateNext = r_state;
      if (w_xfer) begin
         case (r_state)
            ST_SOP:  if (!s_axis_tlast) w_stateNext = ST_BODY;
            ST_BODY: if (s_axis_tlast)  w_stateNext = ST_SOP;
            default: w_stateNext = ST_SOP;
         endcase
      end
   end

   // Statistics. Clear has priority over a coincident beat, which is then
   // lost. On a packet's first beat an invalid tag is counted as an error, a
   // lower rank than the last valid one is an inversion (last_rank kept), and
   // otherwise the rank becomes the new reference.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_pktCount     <= '0;
         r_wordCount    <= '0;
         r_byteCount    <= '0;
         r_rankInvCount <= '0;
         r_pifoErrCount <= '0;
         r_lastRank     <= '0;
         r_hasPrev      <= 1'b0;
      end else if (clear_counters) begin
         r_pktCount     <= '0;
         r_wordCount    <= '0;
         r_byteCount    <= '0;
         r_rankInvCount <= '0;
         r_pifoErrCount <= '0;
         r_lastRank     <= '0;
         r_hasPrev      <= 1'b0;
      end else if (w_xfer) begin
         r_wordCount <= satAdd(r_wordCount, 6'd1);
         r_byteCount <= satAdd(r_byteCount, w_keepCount);
         if (s_axis_tlast) begin
            r_pktCount <= satAdd(r_pktCount, 6'd1);
         end
         if (w_sopXfer) begin
            if (!s_axis_tpifo[31]) begin
               r_pifoErrCount <= satAdd(r_pifoErrCount, 6'd1);
            end else if (r_hasPrev && (w_rank < r_lastRank)) begin
               r_rankInvCount <= satAdd(r_rankInvCount, 6'd1);
            end else begin
               r_lastRank <= w_rank;
               r_hasPrev  <= 1'b1;
            end
         end
      end
   end

   // Register file read mux, word-indexed by ARADDR[5:2].
   always_comb begin
      w_readMux = 32'h0;
      case (S_AXI_ARADDR[5:2])
         4'd0:    w_readMux = r_pktCount;
         4'd1:    w_readMux = r_wordCount;
         4'd2:    w_readMux = r_byteCount;
         4'd3:    w_readMux = r_rankInvCount;
         4'd4:    w_readMux = r_pifoErrCount;
         4'd5:    w_readMux = {13'b0, r_lastRank};
         4'd6:    w_readMux = {29'b0, r_hasPrev, (r_state == ST_BODY), r_tready};
         4'd7:    w_readMux = ID_VALUE;
         default: w_readMux = 32'h0;
      endcase
   end

   // Single-outstanding read: ARREADY drops on the address handshake, the
   // response holds until accepted, and ARREADY comes back the cycle after.
   // The idle branch raises ARREADY on the first clock after reset.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else if (S_AXI_ARVALID && r_arready) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b1;
         r_rdata   <= w_readMux;
      end else if (r_rvalid && S_AXI_RREADY) begin
         r_rvalid  <= 1'b0;
         r_arready <= 1'b1;
      end else if (!r_rvalid) begin
         r_arready <= 1'b1;
      end
   end

endmodule

// File: doc/scheduler_port_sink.md
# scheduler_port_sink

Egress sink for one scheduler output port (the `m_axis_N_*` interface). It consumes the AXI-Stream beats, paces `tready` with a programmable back-pressure pattern, and checks packet framing and the PIFO tag. It also tracks rank inversions between consecutive packets. All statistics are readable through an AXI4-Lite read-only slave, so bench or CPU software can check scheduler output order without a waveform viewer.

## Interface
- `READY_PATTERN`, default `8'hFF`: per-cycle `tready` mask, LSB first; rotates every clock.
- `C_S_AXI_ADDR_WIDTH`, default 32: AXI-Lite address width.
- `C_S_AXI_DATA_WIDTH`, default 32: AXI-Lite data width (only 32 supported).
- `axis_aclk`  in  1  sole clock; AXI-Lite shares it.
- `axis_resetn`  in  1  reset, asynchronous, active-low.
- `sink_enable`  in  1  gates `tready`; 0 forces `tready`=0.
- `clear_counters`  in  1  synchronous one-cycle clear of all statistics.
- `s_axis_tdata`  in  256  packet data (not stored).
- `s_axis_tkeep`  in  32  byte enables.
- `s_axis_tuser`  in  128  metadata (not checked).
- `s_axis_tpifo`  in  32  PIFO tag: bit 31 = tag valid, bits 30:12 = rank (19 b), bits 11:0 reserved.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tlast`  in  1  last beat of packet.
- `s_axis_tready`  out  1  sink ready, registered.
- `S_AXI_ARADDR`  in  32  read address.
- `S_AXI_ARVALID`  in  1  read address valid.
- `S_AXI_ARREADY`  out  1  read address ready.
- `S_AXI_RDATA`  out  32  read data.
- `S_AXI_RRESP`  out  2  read response.
- `S_AXI_RVALID`  out  1  read data valid.
- `S_AXI_RREADY`  in  1  read data ready.

## Operation
- Beat accepted ("xfer") when `tvalid & tready` at a rising edge.
- Framing FSM:
  - SOP: on xfer, go to BODY unless `tlast`=1; a `tlast` beat completes a one-word packet and stays in SOP.
  - BODY: on xfer with `tlast`=1, return to SOP.
- On every xfer:
  - `word_count` += 1.
  - `byte_count` += popcount(`tkeep`), 0..32.
- On `tlast` xfer: `pkt_count` += 1.
- On SOP xfer (first beat of a packet), the PIFO tag is checked:
  - If `tpifo[31]`=0: `pifo_err_count` += 1; rank is not captured.
  - Otherwise, if `has_prev`=1 and rank < `last_rank`: `rank_inv_count` += 1.
  - Otherwise (tag valid): `last_rank` ← rank and `has_prev` ← 1.
  - Comparison is unsigned, 19 b.
- Counters are 32 b and saturate at `32'hFFFF_FFFF` (no wrap).
- `clear_counters` zeroes all counters, `last_rank` and `has_prev`. When clear coincides with an xfer, clear wins and that beat is not counted. FSM state is not cleared.
- AXI-Lite read map, decoded on `ARADDR[5:2]`:
  - 0 `pkt_count`
  - 1 `word_count`
  - 2 `byte_count`
  - 3 `rank_inv_count`
  - 4 `pifo_err_count`
  - 5 `{13'b0, last_rank}`
  - 6 status `{29'b0, has_prev, fsm_in_body, tready}`
  - 7 ID `32'h5C4E_0001`
  - All other `ARADDR` bits are ignored; `RRESP` is always `2'b00`.
- Write channel is not implemented.

## Timing
- Reset values: `s_axis_tready`=0, `S_AXI_ARREADY`=0, `S_AXI_RVALID`=0, `S_AXI_RDATA`=0, `S_AXI_RRESP`=0, all counters 0, `last_rank`=0, `has_prev`=0, FSM=SOP, pattern phase=0.
- First cycle after reset release: `ARREADY`=1 and `tready`=`sink_enable & READY_PATTERN[0]`.
- `tready` is registered. The value seen in cycle n is `sink_enable`(n−1) & `READY_PATTERN[phase]`, where phase = n mod 8 from reset release.
- Counters and `last_rank` update at the xfer edge and are visible to a read one cycle later.
- Read handshake:
  - AR handshake at edge t: `ARREADY` drops.
  - `RDATA` is captured from register values as they stand before edge t; `RVALID`=1 from edge t.
  - `RVALID` and `RDATA` hold until `RVALID & RREADY`; `ARREADY` returns high on the next cycle.
  - One outstanding read; AR-to-R latency is 1 cycle.
- Asserting reset mid-packet aborts the packet: FSM returns to SOP and the partial packet is not counted.
- Reset asserted mid-read drops `RVALID` immediately.

## Test plan
- **Scenario 1.** `READY_PATTERN`=`8'hFF`, enable=1; send a 3-beat packet with full `tkeep`, rank 100 → pkt=1, word=3, byte=96, last_rank=100, inv=0.
- **Scenario 2.** Send packets with ranks 10, 50, 50, 20 → pkt=4, inv=1, last_rank=50.
- **Scenario 3.** `READY_PATTERN`=`8'b0101_0101`, continuous valid for a 6-beat packet → `tready` alternates, all 6 beats are counted, and xfer occurs only on phases 0, 2, 4, 6.
- **Scenario 4.** First beat has `tpifo[31]`=0; then one single-beat packet with `tkeep`=`32'h0000_000F` → pifo_err=1, byte count +4, SOP framing still correct.
- **Scenario 5.** Read addresses 0x00, 0x1C, 0x14 with `RREADY` held low 3 cycles on the second read → `RVALID` and `RDATA` stable for the whole stall, ID `32'h5C4E_0001` returned, `ARREADY` low while pending.
- **Scenario 6.** Pulse `clear_counters` in the same cycle as a `tlast` xfer, then assert reset mid-packet → all counters read 0, the following packet counts from 1, and `tready`=0 during reset.
